// File: rtl/regfile_pkg.sv
// Shared constants and types for the register-file write-port controller.
//   NUM_REGS / REG_AW / REG_DW : register file geometry (32 x 32)
//   state_t                    : controller phase, INIT (zero sweep) or RUN
//   reg_addr_t                 : register index type
package regfile_pkg;

  localparam int NUM_REGS = 32;
  localparam int REG_AW   = 5;
  localparam int REG_DW   = 32;

  // Two-phase controller; plain constants keep the encoding visible to
  // older tools and waveform viewers.
  typedef logic [0:0] state_t;
  localparam state_t INIT = 1'b0;
  localparam state_t RUN  = 1'b1;

  typedef logic [REG_AW-1:0] reg_addr_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker.
//   req : request vector
//   ptr : highest-priority index this cycle (owned by the parent)
//   gnt : one-hot grant to the first request at or after ptr, with wrap
//   idx : encoded index of gnt (0 when nothing is requested)
module rr_arbiter #(
  parameter  int N  = 3,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);

  // One spare bit so ptr + k (at most 2N-2) cannot overflow before the wrap.
  logic [IW:0]   sum;
  logic [IW-1:0] cand;

  // Walk the search order backwards so the earliest candidate is the last
  // one written and therefore wins; no "found" flag needed.
  always_comb begin
    gnt  = '0;
    idx  = '0;
    sum  = '0;
    cand = '0;
    for (int k = N - 1; k >= 0; k--) begin
      sum = {1'b0, ptr} + (IW+1)'(k);
      if (sum >= (IW+1)'(N)) sum = sum - (IW+1)'(N);
      cand = sum[IW-1:0];
      if (req[cand]) begin
        gnt       = '0;
        gnt[cand] = 1'b1;
        idx       = cand;
      end
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Write-port controller for the CPU register file.
// After reset it writes zero to every register, then shares the single
// write port among NREQ writeback sources with round-robin arbitration.
//   clk, rst   : clock, asynchronous active-high reset
//   req_valid  : per-requester write request
//   req_addr   : packed destination registers, requester i at [i*AW +: AW]
//   req_data   : packed write data, requester i at [i*DW +: DW]
//   req_ready  : one-hot accept (combinational, RUN only)
//   we_reg     : registered register-file write enable
//   wr_addr    : registered write address
//   wr_data    : registered write data
//   grant_id   : index of the last accepted requester
//   init_done  : high once the zero sweep has finished, until next reset
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter  int NREQ = 3,
  parameter  int AW   = REG_AW,
  parameter  int DW   = REG_DW,
  localparam int GW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]    req_ready,
  output logic               we_reg,
  output logic [AW-1:0]      wr_addr,
  output logic [DW-1:0]      wr_data,
  output logic [GW-1:0]      grant_id,
  output logic               init_done
);

  // Sweep counter runs one past the last register; the extra value marks
  // the idle cycle in which the controller hands over to RUN.
  localparam logic [AW:0] SWEEP_END = (AW+1)'(NUM_REGS);

  state_t          state;
  logic [AW:0]     cnt;
  logic [GW-1:0]   ptr;
  logic [NREQ-1:0] gnt;
  logic [GW-1:0]   gidx;
  logic [GW-1:0]   ptr_next;
  logic            accept;
  logic [AW-1:0]   sel_addr;
  logic [DW-1:0]   sel_data;

  logic [AW-1:0] addr_arr [NREQ];
  logic [DW-1:0] data_arr [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign addr_arr[i] = req_addr[i*AW +: AW];
    assign data_arr[i] = req_data[i*DW +: DW];
  end

  rr_arbiter #(.N(NREQ)) u_rr (
    .req (req_valid),
    .ptr (ptr),
    .gnt (gnt),
    .idx (gidx)
  );

  assign req_ready = (state == RUN) ? gnt : '0;
  assign accept    = |req_ready;
  assign sel_addr  = addr_arr[gidx];
  assign sel_data  = data_arr[gidx];
  assign ptr_next  = (gidx == GW'(NREQ - 1)) ? '0 : gidx + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= INIT;
      cnt       <= '0;
      ptr       <= '0;
      we_reg    <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      grant_id  <= '0;
      init_done <= 1'b0;
    end else if (state == INIT) begin
      if (cnt == SWEEP_END) begin
        state     <= RUN;
        init_done <= 1'b1;
        we_reg    <= 1'b0;
      end else begin
        we_reg  <= 1'b1;
        wr_addr <= cnt[AW-1:0];
        wr_data <= '0;
        cnt     <= cnt + 1'b1;
      end
    end else begin
      // x0 is hard-wired zero: the request is consumed and rotates the
      // pointer, but the write itself is suppressed and the bus holds.
      we_reg <= accept && (sel_addr != '0);
      if (accept) begin
        grant_id <= gidx;
        ptr      <= ptr_next;
        if (sel_addr != '0) begin
          wr_addr <= sel_addr;
          wr_data <= sel_data;
        end
      end
    end
  end

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Write-port controller for the 32×32 CPU register file. After reset it sequences a zero-initialisation sweep of all 32 registers. It then shares the single write port (we_reg / write address / write data) among NREQ writeback requesters using round-robin arbitration with valid/ready handshakes. It sits between the writeback sources (ALU result, load return, debug/CSR path) and the register file's write inputs.

## Interface
Parameters:
- NREQ, 3: number of writeback requesters (2..8)
- AW, 5: register address width
- DW, 32: data width

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  NREQ  per-requester write request
- req_addr  in  NREQ*AW  destination register; requester i in bits [i*AW +: AW]
- req_data  in  NREQ*DW  write data; requester i in bits [i*DW +: DW]
- req_ready  out  NREQ  one-hot accept; combinational
- we_reg  out  1  register-file write enable; registered
- wr_addr  out  AW  register-file write address; registered
- wr_data  out  DW  register-file write data; registered
- grant_id  out  $clog2(NREQ)  index of the last accepted requester; registered
- init_done  out  1  high once the init sweep has completed; registered

## Operation
- States: INIT, RUN. rst forces INIT, with init counter = 0 and round-robin pointer = 0.
- INIT
  - Each cycle, register we_reg=1, wr_addr=cnt, wr_data=0; then cnt++.
  - When cnt==31 has been issued, go to RUN and set init_done=1.
  - req_ready is all-zero throughout INIT.
- RUN
  - req_ready = one-hot grant to the first requester with req_valid=1, searching from pointer p upward with wrap (p, p+1, …, NREQ-1, 0, …).
  - If no request is valid, req_ready = 0.
  - On accept (req_valid[i] & req_ready[i]):
    - next cycle we_reg=1, wr_addr=req_addr[i], wr_data=req_data[i], grant_id=i;
    - p ← (i+1) mod NREQ.
  - With no accept: we_reg=0 next cycle; wr_addr, wr_data and grant_id hold; p holds.
- Writes to register 0 are accepted (ready returned) but dropped: we_reg stays 0, grant_id and p still update. x0 therefore stays zero.
- Only one accept per cycle. Unaccepted requesters must hold valid, addr and data stable until ready.
- init_done stays high until the next rst.

## Timing
- Reset values: we_reg=0, wr_addr=0, wr_data=0, grant_id=0, init_done=0, req_ready=0.
- Init sweep:
  - Edge 1 after rst deassert: wr_addr=0, we_reg=1.
  - Edge 32: wr_addr=31.
  - Edge 33: init_done=1, we_reg=0; req_ready may assert in the same cycle.
- Accept-to-write latency: accept in cycle t gives we_reg high during cycle t+1. The register file captures at the end of t+1.
- Back-to-back accepts are allowed every cycle. Maximum throughput is one write per cycle.
- req_ready depends combinationally on req_valid and the state. It never depends on anything downstream.
- rst mid-sweep or mid-RUN: outputs return to reset values immediately (asynchronous), and the sweep restarts from address 0. A request accepted in the cycle rst asserts is lost.
- Starvation bound: a continuously valid requester is accepted within NREQ RUN cycles.

## Structure
- Package regfile_pkg:
  - constants NUM_REGS=32, REG_AW=5, REG_DW=32;
  - typedef state_t {INIT, RUN};
  - typedef reg_addr_t.
- Sub-module rr_arbiter:
  - parameter N; inputs req[N] and pointer; outputs one-hot gnt[N] and encoded index;
  - purely combinational; the pointer register lives in the parent.

## Test plan
- Reset release, no requests:
  - we_reg high for exactly 32 cycles with wr_addr 0..31 and wr_data=0;
  - init_done=1 on edge 33;
  - req_ready=0 throughout INIT.
- NREQ=3, all valid continuously from RUN entry (addrs 5/6/7, data A/B/C):
  - grant order 0,1,2,0,1,2;
  - each write appears one cycle after its accept.
- Only requester 2 valid, addr=3, data=0xDEADBEEF:
  - accepted in the first RUN cycle;
  - next cycle we_reg=1, wr_addr=3, wr_data=0xDEADBEEF, grant_id=2; p becomes 0.
- Requester 1 writes addr 0, data 0xFFFFFFFF:
  - req_ready[1]=1 and grant_id=1 next cycle;
  - we_reg stays 0.
- Assert rst at sweep cycle 10, release:
  - outputs go to zero immediately;
  - sweep restarts at wr_addr=0 and init_done rises 33 edges after release.
- Requester 0 valid for 4 cycles while 1 and 2 toggle:
  - requester 0 accepted within 3 cycles;
  - its addr and data are held stable until accept.
